// File: rtl/eth_10g_tx_st_pkt_arbiter.sv
// Packet-level round-robin arbiter merging two Avalon-ST TX sources onto the 10G MAC TX stream.
// Optional inter-packet gap state enabled by defining ETH_TX_ARB_IPG_EN.
module eth_10g_tx_st_pkt_arbiter #(
    parameter int DATA_W     = 64,
    parameter int EMPTY_W    = 3,
    parameter int CNT_W      = 16,
    parameter int IPG_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  in0_data,
    input  logic               in0_valid,
    input  logic               in0_sop,
    input  logic               in0_eop,
    input  logic [EMPTY_W-1:0] in0_empty,
    input  logic               in0_error,
    output logic               in0_ready,
    input  logic [DATA_W-1:0]  in1_data,
    input  logic               in1_valid,
    input  logic               in1_sop,
    input  logic               in1_eop,
    input  logic [EMPTY_W-1:0] in1_empty,
    input  logic               in1_error,
    output logic               in1_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    output logic               out_error,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   pkt_cnt0,
    output logic [CNT_W-1:0]   pkt_cnt1,
    output logic [CNT_W-1:0]   proto_err_cnt
);
    typedef enum logic [1:0] {IDLE, ACTIVE, IPG} state_e;

    state_e             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0]   pkt_cnt1_q, pkt_cnt1_d;
    logic [CNT_W-1:0]   perr_q, perr_d;
    logic [1:0]         valid_v, sop_v, eop_v, cand, stray, rdy;
    logic [1:0]         drops;
    logic [CNT_W:0]     perr_sum;
    logic               out_vld;

`ifdef ETH_TX_ARB_IPG_EN
    // A zero gap request still spends one cycle in IPG.
    localparam int IPG_EFF = (IPG_CYCLES < 1) ? 1 : IPG_CYCLES;
    localparam int IPG_W   = $clog2(IPG_EFF + 1);
    logic [IPG_W-1:0]   ipg_cnt_q, ipg_cnt_d;
`else
    localparam int IPG_UNUSED = IPG_CYCLES;
`endif

    assign valid_v  = {in1_valid, in0_valid};
    assign sop_v    = {in1_sop, in0_sop};
    assign eop_v    = {in1_eop, in0_eop};
    assign cand     = valid_v & sop_v;
    assign stray    = valid_v & ~sop_v;
    assign drops    = {1'b0, stray[0]} + {1'b0, stray[1]};
    assign perr_sum = {1'b0, perr_q} + (CNT_W+1)'(drops);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_cnt0_d   = pkt_cnt0_q;
        pkt_cnt1_d   = pkt_cnt1_q;
        perr_d       = perr_q;
        rdy          = 2'b00;
        out_vld      = 1'b0;
`ifdef ETH_TX_ARB_IPG_EN
        ipg_cnt_d    = ipg_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                rdy    = stray;
                perr_d = perr_sum[CNT_W] ? {CNT_W{1'b1}} : perr_sum[CNT_W-1:0];
                if (|cand) begin
                    state_d = ACTIVE;
                    grant_d = (&cand) ? ~last_grant_q : cand[1];
                end
            end
            ACTIVE: begin
                out_vld      = valid_v[grant_q];
                rdy[grant_q] = out_ready;
                if (valid_v[grant_q] && out_ready && eop_v[grant_q]) begin
                    if (grant_q) pkt_cnt1_d = pkt_cnt1_q + 1'b1;
                    else         pkt_cnt0_d = pkt_cnt0_q + 1'b1;
                    last_grant_d = grant_q;
`ifdef ETH_TX_ARB_IPG_EN
                    state_d   = IPG;
                    ipg_cnt_d = IPG_W'(IPG_EFF - 1);
`else
                    state_d   = IDLE;
`endif
                end
            end
            IPG: begin
`ifdef ETH_TX_ARB_IPG_EN
                if (ipg_cnt_q == '0) state_d = IDLE;
                else                 ipg_cnt_d = ipg_cnt_q - 1'b1;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
            perr_q       <= '0;
`ifdef ETH_TX_ARB_IPG_EN
            ipg_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
            perr_q       <= perr_d;
`ifdef ETH_TX_ARB_IPG_EN
            ipg_cnt_q    <= ipg_cnt_d;
`endif
        end
    end

    // Readies are forced low while reset is held, even for stray beats seen in IDLE.
    assign in0_ready     = rdy[0] & reset_n;
    assign in1_ready     = rdy[1] & reset_n;
    assign out_valid     = out_vld;
    assign out_data      = grant_q ? in1_data  : in0_data;
    assign out_sop       = grant_q ? in1_sop   : in0_sop;
    assign out_eop       = grant_q ? in1_eop   : in0_eop;
    assign out_empty     = grant_q ? in1_empty : in0_empty;
    assign out_error     = grant_q ? in1_error : in0_error;
    assign pkt_cnt0      = pkt_cnt0_q;
    assign pkt_cnt1      = pkt_cnt1_q;
    assign proto_err_cnt = perr_q;
endmodule

// File: tb/tb_eth_10g_tx_st_pkt_arbiter.sv
// Self-checking bench for eth_10g_tx_st_pkt_arbiter: queue-driven sources, packet-level round-robin model.
module tb_eth_10g_tx_st_pkt_arbiter;
    localparam int DW  = 64;
    localparam int EW  = 3;
    localparam int CW  = 16;
    localparam int IPGC = 3;
`ifdef ETH_TX_ARB_IPG_EN
    localparam int GAP = IPGC + 2;
`else
    localparam int GAP = 2;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        logic          err;
    } beat_t;

    logic          clk, reset_n;
    logic [DW-1:0] in0_data, in1_data, out_data;
    logic          in0_valid, in0_sop, in0_eop, in0_error, in0_ready;
    logic          in1_valid, in1_sop, in1_eop, in1_error, in1_ready;
    logic [EW-1:0] in0_empty, in1_empty, out_empty;
    logic          out_valid, out_sop, out_eop, out_error, out_ready;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1, proto_err_cnt;

    eth_10g_tx_st_pkt_arbiter #(.DATA_W(DW), .EMPTY_W(EW), .CNT_W(CW), .IPG_CYCLES(IPGC)) dut (
        .clk(clk), .reset_n(reset_n),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_sop(in0_sop), .in0_eop(in0_eop),
        .in0_empty(in0_empty), .in0_error(in0_error), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_sop(in1_sop), .in1_eop(in1_eop),
        .in1_empty(in1_empty), .in1_error(in1_error), .in1_ready(in1_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_error(out_error), .out_ready(out_ready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .proto_err_cnt(proto_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t q0[$], q1[$], m0[$], m1[$], exp_b[$], got_b[$];
    int    got_c[$];
    bit    rp[$];
    int    cyc, acc0, acc1, rdy0_hi, n_cmp, n_err, pk0, pk1, perr;
    bit    lastg, hold_pend;
    logic [DW-1:0] hold_data;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_beat(input int src, input beat_t b);
        if (src == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic mk_pkt(input int src, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data  = {4'(src), 28'($urandom), 32'($urandom)};
            b.sop   = (i == 0);
            b.eop   = (i == n - 1);
            b.empty = EW'($urandom);
            b.err   = 1'($urandom);
            push_beat(src, b);
        end
    endtask

    task automatic mk_stray(input int src, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data  = {32'($urandom), 32'($urandom)};
            b.sop   = 1'b0;
            b.eop   = 1'($urandom);
            b.empty = EW'($urandom);
            b.err   = 1'($urandom);
            push_beat(src, b);
        end
    endtask

    // Expected output stream: whole packets, alternating when both sources have one waiting.
    task automatic build_exp();
        beat_t b;
        bit    s;
        m0 = q0;
        m1 = q1;
        exp_b.delete();
        while (m0.size() > 0 || m1.size() > 0) begin
            if (m0.size() > 0 && m1.size() > 0) s = ~lastg;
            else                                s = (m0.size() == 0);
            do begin
                b = s ? m1.pop_front() : m0.pop_front();
                exp_b.push_back(b);
            end while (!b.eop);
            if (s) pk1++; else pk0++;
            lastg = s;
        end
    endtask

    task automatic drive();
        beat_t b0, b1;
        b0 = '0;
        b1 = '0;
        if (q0.size() > 0) b0 = q0[0];
        if (q1.size() > 0) b1 = q1[0];
        in0_valid = (q0.size() > 0);
        in0_data = b0.data; in0_sop = b0.sop; in0_eop = b0.eop; in0_empty = b0.empty; in0_error = b0.err;
        in1_valid = (q1.size() > 0);
        in1_data = b1.data; in1_sop = b1.sop; in1_eop = b1.eop; in1_empty = b1.empty; in1_error = b1.err;
        out_ready = 1'b1;
        if (rp.size() > 0) out_ready = rp.pop_front();
    endtask

    task automatic step();
        beat_t g, d;
        drive();
        #1;
        if (hold_pend) chk("hold_data", out_data, hold_data);
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        if (in0_ready && q1.size() > 0) rdy0_hi++;
        if (in0_valid && in0_ready) begin acc0++; d = q0.pop_front(); end
        if (in1_valid && in1_ready) begin acc1++; d = q1.pop_front(); end
        if (out_valid && out_ready) begin
            g = {out_data, out_sop, out_eop, out_empty, out_error};
            got_b.push_back(g);
            got_c.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input string tag, input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, q0.size() + q1.size(), 0);
    endtask

    task automatic clear_obs();
        got_b.delete(); got_c.delete(); rp.delete();
        acc0 = 0; acc1 = 0; rdy0_hi = 0; hold_pend = 1'b0;
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        chk({tag, "_len"}, got_b.size(), exp_b.size());
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), got_b[i], exp_b[i]);
    endtask

    task automatic chk_gaps(input string tag);
        for (int i = 1; i < got_c.size(); i++)
            chk($sformatf("%s_gap%0d", tag, i), got_c[i] - got_c[i-1], got_b[i-1].eop ? GAP : 1);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_pkt_cnt0"}, pkt_cnt0, pk0);
        chk({tag, "_pkt_cnt1"}, pkt_cnt1, pk1);
        chk({tag, "_proto_err"}, proto_err_cnt, perr);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q0.delete(); q1.delete();
        clear_obs();
        drive();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pk0 = 0; pk1 = 0; perr = 0; lastg = 1'b1;
    endtask

    initial begin
        int c0, n;
        n_cmp = 0; n_err = 0; cyc = 0;
        reset_n = 1'b0;
        clear_obs();

        // Reset state, with stray beats asserted on both inputs during reset.
        mk_stray(0, 1);
        mk_stray(1, 1);
        drive();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in0_ready", in0_ready, 1'b0);
        chk("rst_in1_ready", in1_ready, 1'b0);
        @(negedge clk);
        do_reset();
        chk_cnts("rst");

        // Single 4-beat packet from in0.
        mk_pkt(0, 4);
        build_exp();
        c0 = cyc;
        run("t1", 20);
        cmp_stream("t1");
        chk("t1_latency", (got_c.size() > 0) ? got_c[0] - c0 : -1, 1);
        chk_gaps("t1");
        chk_cnts("t1");

        // Three stray beats from in1 while idle.
        clear_obs();
        mk_stray(1, 3);
        c0 = cyc;
        run("t2", 10);
        chk("t2_accepted", acc1, 3);
        chk("t2_cycles", cyc - c0, 3);
        chk("t2_no_output", got_b.size(), 0);
        perr += 3;
        chk_cnts("t2");

        // in1 packet under output backpressure, in0 waiting behind it.
        clear_obs();
        mk_pkt(1, 4);
        mk_pkt(0, 2);
        build_exp();
        rp.push_back(1'b1); rp.push_back(1'b1); rp.push_back(1'b0);
        rp.push_back(1'b0); rp.push_back(1'b1);
        run("t3", 30);
        cmp_stream("t3");
        chk("t3_in0_ready_blocked", rdy0_hi, 0);
        chk_cnts("t3");

        // Both sources request continuously: strict alternation from source 0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mk_pkt(0, 2);
            mk_pkt(1, 2);
        end
        build_exp();
        run("t4", 60);
        cmp_stream("t4");
        chk_gaps("t4");
        chk_cnts("t4");

        // Back-to-back single-beat packets: spacing set by bubble and optional IPG.
        do_reset();
        for (int i = 0; i < 4; i++) mk_pkt(0, 1);
        build_exp();
        run("t5", 40);
        cmp_stream("t5");
        chk_gaps("t5");
        chk_cnts("t5");

        // Double strays every cycle until proto_err_cnt saturates.
        clear_obs();
        mk_stray(0, 32800);
        mk_stray(1, 32800);
        run("t6", 33000);
        perr = perr + 65600;
        if (perr > 65535) perr = 65535;
        chk("t6_no_output", got_b.size(), 0);
        chk_cnts("t6");

        // Asynchronous reset in the middle of a 5-beat packet.
        clear_obs();
        mk_pkt(0, 5);
        build_exp();
        n = 0;
        while (acc0 < 2 && n < 20) begin
            step();
            n++;
        end
        chk("t7_two_beats", acc0, 2);
        drive();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t7_out_valid", out_valid, 1'b0);
        chk("t7_in0_ready", in0_ready, 1'b0);
        chk("t7_in1_ready", in1_ready, 1'b0);
        pk0 = 0; pk1 = 0; perr = 0;
        chk_cnts("t7");
        @(negedge clk);
        do_reset();
        mk_pkt(1, 1);
        mk_pkt(0, 1);
        build_exp();
        run("t8", 20);
        cmp_stream("t8");
        chk("t8_first_src", (got_b.size() > 0) ? got_b[0].data[DW-1:DW-4] : 4'hf, 4'h0);
        chk_cnts("t8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/eth_10g_tx_st_pkt_arbiter.md
Name: eth_10g_tx_st_pkt_arbiter

Overview:
- Packet-level round-robin arbiter for two Avalon-ST TX sources (in0 and in1) feeding the single 10G MAC TX stream, upstream of the TX timing adapter/splitter.
- Grants one source for a whole packet (SOP to EOP) and forwards its beats with zero added latency while granted.
- Swallows stray mid-packet beats arriving while no packet is open.
- Keeps per-source packet counters and a protocol-error counter for the JTAG debug path.

Parameters:
- DATA_W, 64: data width per beat.
- EMPTY_W, 3: empty field width; must equal log2(DATA_W/8).
- CNT_W, 16: width of all statistics counters.
- IPG_CYCLES, 3: minimum idle output cycles between packets. Used only with ETH_TX_ARB_IPG_EN.

Ports:
- clk  in  1  single clock for the whole block
- reset_n  in  1  asynchronous active-low reset
- inN_data  in  DATA_W  source N payload (N = 0, 1; each inN_* port exists for both sources)
- inN_valid  in  1  source N valid
- inN_sop  in  1  source N start of packet
- inN_eop  in  1  source N end of packet
- inN_empty  in  EMPTY_W  source N empty bytes, meaningful on EOP
- inN_error  in  1  source N error, meaningful on EOP
- inN_ready  out  1  source N ready
- out_data  out  DATA_W  granted payload to MAC TX
- out_valid  out  1  output valid
- out_sop, out_eop  out  1  output start and end of packet
- out_empty  out  EMPTY_W  output empty bytes
- out_error  out  1  output error
- out_ready  in  1  MAC TX ready
- pkt_cnt0, pkt_cnt1  out  CNT_W  packets forwarded per source; wraps
- proto_err_cnt  out  CNT_W  stray beats dropped; saturates at all-ones

Behaviour:
- Handshake: a beat transfers when valid and ready are both high in the same cycle.
- Reset (reset_n low, asynchronous):
  - state = IDLE, grant = 0, last_grant = 1, so source 0 wins first.
  - All counters = 0.
  - out_valid = 0; in0_ready = in1_ready = 0.
- IDLE state:
  - A source is a candidate when its valid and sop are both high.
  - Both candidates present: grant goes to the source that is not last_grant.
  - One candidate present: grant goes to that source.
  - A candidate exists: next state = ACTIVE. No beat is accepted in this cycle, giving a 1-cycle arbitration bubble.
  - Stray beat (valid high, sop low): the source's ready = 1 and the beat is dropped. proto_err_cnt += 1 per dropped beat; both sources dropping in one cycle counts +2, saturating. Drops happen in the same cycle as a grant decision.
  - out_valid = 0 throughout IDLE.
- ACTIVE state (source g granted):
  - Outputs driven combinationally from source g: out_* = ing_*, out_valid = ing_valid, ing_ready = out_ready.
  - The non-granted source's ready = 0, so it is backpressured and not dropped.
  - A granted beat with sop high after the first beat is forwarded unchanged. No repair is attempted.
  - On an accepted EOP beat (valid, ready, eop all high):
    - pkt_cnt[g] += 1, wrapping.
    - last_grant = g.
    - next state = IDLE, or IPG when the feature is enabled.
- out_ready low while ACTIVE: outputs hold the current beat, and the source is responsible for holding it. State is unchanged.
- SOP and EOP on the same beat (single-beat packet): counted once, and the block returns to IDLE.
- Latency: 0 cycles data path while ACTIVE; 1 cycle from SOP presented in IDLE to first out_valid.
- Fairness: with both sources continuously requesting, packets alternate strictly 0, 1, 0, 1.

Optional Feature:
- Macro: ETH_TX_ARB_IPG_EN.
- Defined:
  - After EOP acceptance, enter state IPG with a down-counter loaded to IPG_CYCLES-1.
  - In IPG, out_valid = 0 and both readies = 0. Stray beats are not dropped in IPG.
  - Return to IDLE when the counter reaches 0.
  - Total output gap between packets = IPG_CYCLES + 1, including the arbitration bubble.
  - IPG_CYCLES = 0 is treated as 1.
- Undefined: no IPG state; the gap between packets is exactly 1 cycle.

Test Plan:
- Reset, then in0 sends a 4-beat packet with out_ready = 1:
  - First out_valid appears 1 cycle after in0_valid and in0_sop go high.
  - 4 consecutive output beats, with out_empty = in0_empty on EOP.
  - pkt_cnt0 = 1.
- in0 and in1 both request continuously, 3 packets each of 2 beats:
  - Output order is 0, 1, 0, 1, 0, 1 with a 1-cycle gap between packets.
  - pkt_cnt0 = pkt_cnt1 = 3.
- in1 sends 3 stray beats (sop = 0) while in IDLE:
  - in1_ready is high on each, and nothing appears on the output.
  - proto_err_cnt = 3.
- out_ready toggles 1,0,0,1 during an in1 packet:
  - out_data is stable while out_ready is low.
  - in0_ready stays 0 throughout.
  - No beat is lost or duplicated.
- reset_n asserted mid-packet, on beat 2 of 5:
  - out_valid and both readies go to 0 immediately (asynchronous).
  - All counters read 0.
  - After release, source 0 wins the first tie.
- Build with ETH_TX_ARB_IPG_EN and IPG_CYCLES = 3, back-to-back single-beat packets:
  - Output beats are exactly 5 cycles apart (1 beat + 3 IPG + 1 arbitration cycle).
